// File: rtl/inertial_interface.sv
// IMU front end: configures the IMU over an external 16-bit SPI master once
// after a power-up wait, then reads pitch rate and Z accel on every data-ready.
module inertial_interface #(
  parameter int unsigned INIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  typedef enum logic [2:0] {
    StWaitTmr,
    StCfg,
    StWaitInt,
    StRead,
    StVld
  } state_t;

  state_t                 r_state;
  logic [INIT_BITS-1:0]   r_timer;
  logic [1:0]             r_idx;
  logic                   r_pend;   // a wrt has been issued and its done not yet seen
  logic                   r_wrt;
  logic [15:0]            r_cmd;
  logic [7:0]             r_ptch_lo;
  logic [7:0]             r_ptch_hi;
  logic [7:0]             r_az_lo;
  logic [7:0]             r_az_hi;
  logic [15:0]            r_ptch_rt;
  logic [15:0]            r_az;
  logic                   r_vld;
  logic                   r_int_ff1;
  logic                   r_int_ff2;

  logic                   w_timer_sat;
  logic                   w_unused_rd_hi;

  assign w_timer_sat    = &r_timer;
  // Only the low byte of each SPI response carries data.
  assign w_unused_rd_hi = ^rd_data[15:8];

  // IMU configuration words, issued in index order.
  function automatic logic [15:0] cfg_word(input logic [1:0] i);
    unique case (i)
      2'd0:    cfg_word = 16'h0D02;
      2'd1:    cfg_word = 16'h1053;
      2'd2:    cfg_word = 16'h1150;
      default: cfg_word = 16'h1460;
    endcase
  endfunction

  // Register-read commands: pitch lo/hi, then Z accel lo/hi.
  function automatic logic [15:0] rd_word(input logic [1:0] i);
    unique case (i)
      2'd0:    rd_word = 16'hA200;
      2'd1:    rd_word = 16'hA300;
      2'd2:    rd_word = 16'hAC00;
      default: rd_word = 16'hAD00;
    endcase
  endfunction

  // Power-up timer: counts once after reset and then sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!w_timer_sat) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous data-ready line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
    end else begin
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
    end
  end

  // Sequencer: config burst, then one four-byte read burst per data-ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StWaitTmr;
      r_idx     <= 2'd0;
      r_pend    <= 1'b0;
      r_wrt     <= 1'b0;
      r_cmd     <= 16'h0000;
      r_ptch_lo <= 8'h00;
      r_ptch_hi <= 8'h00;
      r_az_lo   <= 8'h00;
      r_az_hi   <= 8'h00;
      r_ptch_rt <= 16'h0000;
      r_az      <= 16'h0000;
      r_vld     <= 1'b0;
    end else begin
      r_wrt <= 1'b0;
      r_vld <= 1'b0;
      unique case (r_state)
        StWaitTmr: begin
          if (w_timer_sat) begin
            r_state <= StCfg;
            r_idx   <= 2'd0;
            r_pend  <= 1'b0;
          end
        end

        StCfg: begin
          if (!r_pend) begin
            if (!done) begin
              r_wrt  <= 1'b1;
              r_cmd  <= cfg_word(r_idx);
              r_pend <= 1'b1;
            end
          end else if (done) begin
            if (r_idx == 2'd3) begin
              r_pend  <= 1'b0;
              r_state <= StWaitInt;
            end else begin
              // Next command goes out in the cycle right after done.
              r_idx <= r_idx + 2'd1;
              r_wrt <= 1'b1;
              r_cmd <= cfg_word(r_idx + 2'd1);
            end
          end
        end

        StWaitInt: begin
          if (r_int_ff2) begin
            r_state <= StRead;
            r_idx   <= 2'd0;
            r_pend  <= 1'b0;
          end
        end

        StRead: begin
          if (!r_pend) begin
            if (!done) begin
              r_wrt  <= 1'b1;
              r_cmd  <= rd_word(r_idx);
              r_pend <= 1'b1;
            end
          end else if (done) begin
            unique case (r_idx)
              2'd0:    r_ptch_lo <= rd_data[7:0];
              2'd1:    r_ptch_hi <= rd_data[7:0];
              2'd2:    r_az_lo   <= rd_data[7:0];
              default: r_az_hi   <= rd_data[7:0];
            endcase
            if (r_idx == 2'd3) begin
              // Publish both words on the same edge so vld is high during StVld
              // and the pair is always from one sample.
              r_pend    <= 1'b0;
              r_state   <= StVld;
              r_ptch_rt <= {r_ptch_hi, r_ptch_lo};
              r_az      <= {rd_data[7:0], r_az_lo};
              r_vld     <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
              r_wrt <= 1'b1;
              r_cmd <= rd_word(r_idx + 2'd1);
            end
          end
        end

        StVld: begin
          r_state <= StWaitInt;
        end

        default: begin
          r_state <= StWaitTmr;
        end
      endcase
    end
  end

  assign wrt     = r_wrt;
  assign cmd     = r_cmd;
  assign ptch_rt = r_ptch_rt;
  assign AZ      = r_az;
  assign vld     = r_vld;

endmodule

// File: tb/tb_inertial_interface.sv
// Bench for inertial_interface: SPI master model with fixed 20-clock latency,
// per-cycle protocol/output monitor, table vectors and random read bursts.
module tb_inertial_interface;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;

  inertial_interface #(
    .INIT_BITS(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .INT    (INT),
    .done   (done),
    .rd_data(rd_data),
    .wrt    (wrt),
    .cmd    (cmd),
    .ptch_rt(ptch_rt),
    .AZ     (AZ),
    .vld    (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [15:0] exp_p;
    logic [15:0] exp_a;
  } vec_t;

  int          checks;
  int          errors;
  int          wrt_cnt;
  int          vld_cnt;
  int          spi_cnt;
  logic [15:0] spi_cmd;
  logic [15:0] cmd_log[$];
  logic [7:0]  bytes[4];
  bit          stray_req;
  logic [15:0] model_p;
  logic [15:0] model_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response byte the IMU returns for a register read; anything else is noise.
  function automatic logic [7:0] resp_byte(input logic [15:0] c);
    case (c[15:8])
      8'hA2:   return bytes[0];
      8'hA3:   return bytes[1];
      8'hAC:   return bytes[2];
      8'hAD:   return bytes[3];
      default: return 8'($urandom);
    endcase
  endfunction

  // SPI master model plus monitor, sampled 1 time unit after each rising edge.
  initial begin
    done    = 1'b0;
    rd_data = 16'h0000;
    spi_cnt = 0;
    model_p = 16'h0000;
    model_a = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      done = 1'b0;
      if (!rst_n) begin
        spi_cnt = 0;
        model_p = 16'h0000;
        model_a = 16'h0000;
      end else begin
        if (stray_req) begin
          stray_req = 1'b0;
          done      = 1'b1;
          rd_data   = 16'($urandom);
        end else if (spi_cnt > 0) begin
          spi_cnt--;
          if (spi_cnt == 0) begin
            done    = 1'b1;
            rd_data = {8'($urandom), resp_byte(spi_cmd)};
          end
        end
        if (wrt) begin
          chk("wrt_overlap_or_during_done", {31'd0, (spi_cnt != 0) || done}, 32'd0);
          cmd_log.push_back(cmd);
          wrt_cnt++;
          spi_cnt = 20;
          spi_cmd = cmd;
        end else if (spi_cnt > 0) begin
          chk("cmd_hold", {16'd0, cmd}, {16'd0, spi_cmd});
        end
        if (vld) begin
          vld_cnt++;
          model_p = {bytes[1], bytes[0]};
          model_a = {bytes[3], bytes[2]};
        end
        chk("ptch_rt_model", {16'd0, ptch_rt}, {16'd0, model_p});
        chk("AZ_model", {16'd0, AZ}, {16'd0, model_a});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_vld(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (vld_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    chk(name, {31'd0, vld_cnt >= target}, 32'd1);
  endtask

  task automatic wait_cfg(input int target, input string name);
    int n;
    n = 0;
    while (!(wrt_cnt >= target && spi_cnt == 0) && n < 600) begin
      step(1);
      n++;
    end
    chk(name, {31'd0, wrt_cnt >= target && spi_cnt == 0}, 32'd1);
  endtask

  task automatic pulse_int(input int len);
    @(negedge clk);
    INT = 1'b1;
    repeat (len) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic set_bytes(input logic [7:0] b0, b1, b2, b3);
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    bytes[3] = b3;
  endtask

  // One data-ready pulse must yield exactly one four-read burst and one vld.
  task automatic burst(input int len, input string name);
    int v0;
    int w0;
    v0 = vld_cnt;
    w0 = wrt_cnt;
    pulse_int(len);
    wait_vld(v0 + 1, 400, {name, "_vld_seen"});
    step(60);
    chk({name, "_vld_count"}, vld_cnt - v0, 1);
    chk({name, "_wrt_count"}, wrt_cnt - w0, 4);
  endtask

  task automatic check_cfg_log(input int base, input string name);
    logic [15:0] cfg[4];
    cfg[0] = 16'h0D02;
    cfg[1] = 16'h1053;
    cfg[2] = 16'h1150;
    cfg[3] = 16'h1460;
    for (int i = 0; i < 4; i++) begin
      if (base + i < cmd_log.size())
        chk($sformatf("%s_cmd%0d", name, i), {16'd0, cmd_log[base + i]}, {16'd0, cfg[i]});
      else
        chk($sformatf("%s_cmd%0d_missing", name, i), 32'd0, 32'd1);
    end
  endtask

  initial begin
    vec_t        vecs[4];
    logic [15:0] rd_cmds[4];
    int          base;
    int          v0;
    int          w0;
    int          n;
    logic [7:0]  r0, r1, r2, r3;

    checks    = 0;
    errors    = 0;
    wrt_cnt   = 0;
    vld_cnt   = 0;
    stray_req = 1'b0;
    INT       = 1'b0;
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    vecs[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 16'h1234, 16'hABCD};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{8'h01, 8'h80, 8'hFE, 8'h7F, 16'h8001, 16'h7FFE};
    rd_cmds[0] = 16'hA200;
    rd_cmds[1] = 16'hA300;
    rd_cmds[2] = 16'hAC00;
    rd_cmds[3] = 16'hAD00;

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wrt", {31'd0, wrt}, 32'd0);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_ptch_rt", {16'd0, ptch_rt}, 32'd0);
    chk("rst_AZ", {16'd0, AZ}, 32'd0);
    chk("rst_vld", {31'd0, vld}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Power-up wait then config sequence
    step(15);
    chk("timer_no_wrt", wrt_cnt, 0);
    wait_cfg(4, "cfg_done");
    check_cfg_log(0, "cfg");
    step(30);
    chk("cfg_no_extra_wrt", wrt_cnt, 4);

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      set_bytes(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      burst(3, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ptch_rt", i), {16'd0, ptch_rt}, {16'd0, vecs[i].exp_p});
      chk($sformatf("vec%0d_AZ", i), {16'd0, AZ}, {16'd0, vecs[i].exp_a});
      if (i == 0) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("rd_cmd%0d", k), {16'd0, cmd_log[cmd_log.size() - 4 + k]},
              {16'd0, rd_cmds[k]});
      end
    end

    // Long idle: nothing happens, outputs hold the last sample
    v0 = vld_cnt;
    w0 = wrt_cnt;
    step(1000);
    chk("idle_wrt", wrt_cnt - w0, 0);
    chk("idle_vld", vld_cnt - v0, 0);
    chk("idle_ptch_rt", {16'd0, ptch_rt}, {16'd0, vecs[3].exp_p});
    chk("idle_AZ", {16'd0, AZ}, {16'd0, vecs[3].exp_a});

    // Data-ready pulse in the middle of a burst is not queued
    set_bytes(8'h5A, 8'hC3, 8'h96, 8'h0F);
    v0 = vld_cnt;
    w0 = wrt_cnt;
    pulse_int(3);
    step(50);
    pulse_int(3);
    wait_vld(v0 + 1, 400, "midint_vld_seen");
    step(150);
    chk("midint_vld_count", vld_cnt - v0, 1);
    chk("midint_wrt_count", wrt_cnt - w0, 4);
    chk("midint_ptch_rt", {16'd0, ptch_rt}, 32'h0000C35A);
    chk("midint_AZ", {16'd0, AZ}, 32'h00000F96);

    // Data-ready still high at vld restarts a burst back to back
    set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
    v0 = vld_cnt;
    w0 = wrt_cnt;
    @(negedge clk);
    INT = 1'b1;
    wait_vld(v0 + 2, 600, "held_two_vld");
    INT = 1'b0;
    step(200);
    chk("held_multi_burst", {31'd0, (vld_cnt - v0) >= 2}, 32'd1);
    chk("held_wrt_per_vld", wrt_cnt - w0, 4 * (vld_cnt - v0));
    chk("held_ptch_rt", {16'd0, ptch_rt}, 32'h00002211);

    // Stray done while waiting for data-ready
    v0 = vld_cnt;
    w0 = wrt_cnt;
    stray_req = 1'b1;
    step(50);
    chk("stray_wrt", wrt_cnt - w0, 0);
    chk("stray_vld", vld_cnt - v0, 0);
    set_bytes(8'h9A, 8'h78, 8'h56, 8'h34);
    burst(2, "after_stray");
    chk("after_stray_ptch_rt", {16'd0, ptch_rt}, 32'h0000789A);
    chk("after_stray_AZ", {16'd0, AZ}, 32'h00003456);

    // Randomized bursts against the byte-assembly rule
    for (int i = 0; i < 8; i++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r3 = 8'($urandom);
      set_bytes(r0, r1, r2, r3);
      burst(int'($urandom_range(1, 5)), $sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d_ptch_rt", i), {16'd0, ptch_rt}, {16'd0, r1, r0});
      chk($sformatf("rnd%0d_AZ", i), {16'd0, AZ}, {16'd0, r3, r2});
    end

    // Reset during the second read byte
    set_bytes(8'hEE, 8'hDD, 8'hCC, 8'hBB);
    w0 = wrt_cnt;
    pulse_int(3);
    n = 0;
    while (wrt_cnt < w0 + 2 && n < 200) begin
      step(1);
      n++;
    end
    chk("rstmid_second_wrt", {31'd0, wrt_cnt >= w0 + 2}, 32'd1);
    step(5);
    rst_n = 1'b0;
    #1;
    chk("rstmid_wrt", {31'd0, wrt}, 32'd0);
    chk("rstmid_cmd", {16'd0, cmd}, 32'd0);
    chk("rstmid_ptch_rt", {16'd0, ptch_rt}, 32'd0);
    chk("rstmid_AZ", {16'd0, AZ}, 32'd0);
    chk("rstmid_vld", {31'd0, vld}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0   = vld_cnt;
    w0   = wrt_cnt;
    base = cmd_log.size();
    step(15);
    chk("rstmid_timer_no_wrt", wrt_cnt - w0, 0);
    wait_cfg(w0 + 4, "rstmid_cfg_done");
    check_cfg_log(base, "rstmid_cfg");
    chk("rstmid_no_vld", vld_cnt - v0, 0);
    set_bytes(8'h02, 8'h01, 8'h04, 8'h03);
    burst(3, "rstmid_after");
    chk("rstmid_after_ptch_rt", {16'd0, ptch_rt}, 32'h00000102);
    chk("rstmid_after_AZ", {16'd0, AZ}, 32'h00000304);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
